prog_mem_loader: RTL and testbench
==================================

// Module: prog_mem_loader
// PURPOSE
// - Write side of the program memory: takes a byte stream, builds 32-bit big-endian words, writes them to sequential
//   word addresses of the instruction RAM, then releases the core from reset.
// - Sits between the host byte link and the program memory write port. The datapath fetches instructions from that
//   memory, word-addressed by PC[7:2].
// PARAMETERS
// - BIT_WIDTH   32  instruction word width; must be a multiple of 8
// - ADDR_WIDTH  6   program memory word-address width; depth = 2**ADDR_WIDTH
// - HOLD_CYCLES 4   cycles core_rst stays high after the last write; >= 1
// PORTS
// - clk         in   1               system clock; every register on rising edge
// - rst         in   1               synchronous, active-high reset
// - in_valid    in   1               byte available on in_data
// - in_ready    out  1               loader accepts a byte; transfer = in_valid && in_ready
// - in_data     in   8               stream byte
// - reload      in   1               single-cycle pulse: restart loading; honoured in S_RUN and S_ERR only
// - wr_en       out  1               program memory write strobe (single cycle)
// - wr_addr     out  ADDR_WIDTH      program memory word address
// - wr_data     out  BIT_WIDTH       program memory write data
// - core_rst    out  1               reset to the datapath; high while loading
// - done        out  1               load finished; core running
// - error       out  1               sticky load error
// BEHAVIOUR
// - Frame format: CNT_HI, CNT_LO (N, 16-bit big-endian word count), then N*BIT_WIDTH/8 data bytes, MSB first.
// - Reset values (rst=1 at an edge): state=S_CNT_HI, in_ready=0 for that cycle, wr_en=0, wr_addr=0, wr_data=0,
//   core_rst=1, done=0, error=0. Reset mid-frame discards the partial word and the count.
// - State S_CNT_HI: in_ready=1. On a transfer, store count[15:8] and go to S_CNT_LO.
// - State S_CNT_LO: in_ready=1. On a transfer, store count[7:0], set the byte index and address to 0, then:
//   - N==0: go to S_HOLD
//   - N>2**ADDR_WIDTH: go to S_ERR
//   - otherwise: go to S_DATA
// - State S_DATA: in_ready=1. Shift each byte into the word register, left-shift by 8. After the last byte of a word
//   goes to S_WRITE.
// - State S_WRITE: in_ready=0, wr_en=1 for exactly 1 cycle, wr_data = assembled word, wr_addr = current address.
//   - Next cycle: address +1 and word count -1.
//   - If words remain: back to S_DATA.
//   - Else: S_CSUM if the checksum feature is compiled in, otherwise S_HOLD.
// - Write latency: wr_en is asserted in the cycle after the transfer of the word's last byte.
// - Address never wraps. N==2**ADDR_WIDTH writes addresses 0..2**ADDR_WIDTH-1 and stops; the address register is
//   ADDR_WIDTH+1 bits internally.
// - State S_HOLD: in_ready=0, core_rst=1. Counts HOLD_CYCLES cycles, then goes to S_RUN.
// - State S_RUN: core_rst=0, done=1, in_ready=0. Input bytes are ignored (not accepted).
//   - reload=1: go to S_CNT_HI; core_rst=1 and done=0 the next cycle.
// - State S_ERR: error=1, core_rst=1, done=0, in_ready=0.
//   - Left only by rst, or by reload, which clears error and goes to S_CNT_HI.
// - reload in S_CNT_HI, S_CNT_LO, S_DATA, S_WRITE, S_CSUM or S_HOLD is ignored.
// - in_valid may drop between bytes at any time; the loader waits indefinitely (no timeout).
// - All outputs are registered. core_rst, done and error change only on a state change.
// CONFIGURATION
// - `define PROG_LOADER_CHECKSUM_EN
//   - Defined: a running XOR of all data bytes (not the count bytes) is kept.
//     - After the last write, state S_CSUM (in_ready=1) accepts 1 byte.
//     - Byte equals the XOR: go to S_HOLD. Otherwise: go to S_ERR.
//     - Writes already issued are not undone.
//   - Undefined: no S_CSUM state and no XOR register; the frame ends after the data bytes.
// TESTING
// - T1: N=2; bytes 00 02 20 08 00 05 00 00 00 00, in_valid held high -> wr_en pulses 2 times, the first at addr 0
//   data 0x20080005. Second write at addr 1, data 0x00000000. core_rst falls HOLD_CYCLES cycles after the 2nd
//   write; done=1.
// - T2: N=0 (00 00) -> no wr_en; core_rst low after HOLD_CYCLES cycles; done=1.
// - T3: N=65 with ADDR_WIDTH=6 (00 41) -> error=1, core_rst=1, in_ready=0, no writes. Then a reload pulse ->
//   error=0, in_ready=1.
// - T4: N=1, in_valid toggled every other cycle, rst asserted after byte 3 -> no write. Restart with 00 01 AA BB CC
//   DD -> single write of 0xAABBCCDD at addr 0.
// - T5: N=64 full depth with random words -> last write at addr 63; no write to address 0 after the last write.
//   Memory readback matches the stream.
// - T6 (PROG_LOADER_CHECKSUM_EN): N=1, word 0x01020304; checksum byte 0x04 -> done=1. Same frame with 0x05 ->
//   error=1, core_rst stays 1.

Source files
------------

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: turns a counted big-endian byte stream into program memory writes, then releases core_rst.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data bytes.
module prog_mem_loader #(
    parameter int BIT_WIDTH   = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    input  logic                  reload,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [BIT_WIDTH-1:0]  wr_data,
    output logic                  core_rst,
    output logic                  done,
    output logic                  error
);
    localparam int BPW = BIT_WIDTH / 8;
    localparam int IW  = BPW > 1 ? $clog2(BPW) : 1;
    localparam int HW  = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_CNT_HI, S_CNT_LO, S_DATA, S_WRITE, S_HOLD, S_RUN, S_ERR
`ifdef PROG_LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t                state, state_nx;
    logic [15:0]           cnt;
    logic [IW-1:0]         idx;
    logic [ADDR_WIDTH:0]   addr;
    logic [BIT_WIDTH-1:0]  word;
    logic [HW-1:0]         hold;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    logic                  xfer, last_byte, too_big, hold_end, more_words;
    logic [15:0]           n;
    logic [ADDR_WIDTH:0]   addr_nx;
    logic [BIT_WIDTH-1:0]  word_nx;

    assign xfer       = in_valid && in_ready;
    assign last_byte  = idx == IW'(BPW - 1);
    assign n          = {cnt[15:8], in_data};
    assign too_big    = 32'(n) > (32'd1 << ADDR_WIDTH);
    assign hold_end   = hold == HW'(HOLD_CYCLES - 1);
    assign addr_nx    = addr + 1'b1;
    assign word_nx    = BIT_WIDTH'({word, in_data});
    // the extra address bit guarantees a full-depth frame can never wrap back to address 0
    assign more_words = cnt != 16'd1 && !addr_nx[ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) state <= S_CNT_HI;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_CNT_HI: state_nx = xfer ? S_CNT_LO : state;
            S_CNT_LO: state_nx = !xfer ? state : n == 16'd0 ? S_HOLD : too_big ? S_ERR : S_DATA;
            S_DATA:   state_nx = xfer && last_byte ? S_WRITE : state;
`ifdef PROG_LOADER_CHECKSUM_EN
            S_WRITE:  state_nx = more_words ? S_DATA : S_CSUM;
            S_CSUM:   state_nx = !xfer ? state : in_data == csum ? S_HOLD : S_ERR;
`else
            S_WRITE:  state_nx = more_words ? S_DATA : S_HOLD;
`endif
            S_HOLD:   state_nx = hold_end ? S_RUN : state;
            S_RUN:    state_nx = reload ? S_CNT_HI : state;
            S_ERR:    state_nx = reload ? S_CNT_HI : state;
            default:  state_nx = S_CNT_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            core_rst <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            cnt      <= '0;
            idx      <= '0;
            addr     <= '0;
            word     <= '0;
            hold     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            // outputs follow the next state so they are registered yet aligned with the state
            in_ready <= !(state_nx inside {S_WRITE, S_HOLD, S_RUN, S_ERR});
            wr_en    <= state_nx == S_WRITE;
            core_rst <= state_nx != S_RUN;
            done     <= state_nx == S_RUN;
            error    <= state_nx == S_ERR;
            hold     <= state == S_HOLD ? hold + 1'b1 : '0;
            if (state == S_CNT_HI && xfer) cnt[15:8] <= in_data;
            if (state == S_CNT_LO && xfer) begin
                cnt[7:0] <= in_data;
                idx      <= '0;
                addr     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum     <= '0;
`endif
            end
            if (state == S_DATA && xfer) begin
                word <= word_nx;
                idx  <= last_byte ? '0 : idx + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum <= csum ^ in_data;
`endif
                if (last_byte) begin
                    wr_data <= word_nx;
                    wr_addr <= addr[ADDR_WIDTH-1:0];
                end
            end
            if (state == S_WRITE) begin
                addr <= addr_nx;
                cnt  <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: directed frames with hand-computed words, addresses and handshake timing.
module tb_prog_mem_loader;
    logic        clk = 1'b0;
    logic        rst, in_valid, reload;
    logic [7:0]  in_data;
    logic        in_ready, wr_en, core_rst, done, error;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;

    logic [31:0] mem [64];
    logic [31:0] exp_mem [64];
    int          nwr = 0, last_addr = -1;
    int          passed = 0, total = 0;

    prog_mem_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .reload(reload), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .core_rst(core_rst), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (wr_en) begin
        mem[wr_addr] <= wr_data;
        nwr          <= nwr + 1;
        last_addr    <= int'(wr_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int k = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && k < 100) begin
            tick;
            k++;
        end
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
        tick;
        in_valid = 1'b0;
    endtask

    task automatic send_slow(input logic [7:0] b);
        in_valid = 1'b0;
        tick;
        send(b);
    endtask

    task automatic csum(input logic [7:0] x);
`ifdef PROG_LOADER_CHECKSUM_EN
        send(x);
`else
        if (x !== 8'hxx) tick;
`endif
    endtask

    task automatic pulse_reload;
        reload = 1'b1;
        tick;
        reload = 1'b0;
    endtask

    task automatic wait_run;
        int k = 0;
        while (!done && k < 40) begin
            tick;
            k++;
        end
        check("wait_run_done", 32'(done), 32'd1);
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0]  x;
        int          base, errs;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
        tick;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        rst = 1'b0;
        tick;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // T1: two words, in_valid held high
        send(8'h00); send(8'h02);
        send(8'h20); send(8'h08); send(8'h00); send(8'h05);
        check("t1_w0_en", 32'(wr_en), 32'd1);
        check("t1_w0_addr", 32'(wr_addr), 32'd0);
        check("t1_w0_data", wr_data, 32'h2008_0005);
        check("t1_w0_ready", 32'(in_ready), 32'd0);
        send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        check("t1_w1_en", 32'(wr_en), 32'd1);
        check("t1_w1_addr", 32'(wr_addr), 32'd1);
        check("t1_w1_data", wr_data, 32'h0000_0000);
        csum(8'h2D);
        check("t1_hold_wr_en", 32'(wr_en), 32'd0);
        repeat (3) tick;
        check("t1_hold_core_rst", 32'(core_rst), 32'd1);
        check("t1_hold_done", 32'(done), 32'd0);
        tick;
        check("t1_run_core_rst", 32'(core_rst), 32'd0);
        check("t1_run_done", 32'(done), 32'd1);
        check("t1_nwr", 32'(nwr), 32'd2);
        in_valid = 1'b1;
        tick;
        check("t1_run_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // T2: empty frame
        pulse_reload;
        check("t2_reload_core_rst", 32'(core_rst), 32'd1);
        check("t2_reload_done", 32'(done), 32'd0);
        check("t2_reload_ready", 32'(in_ready), 32'd1);
        send(8'h00); send(8'h00);
        repeat (3) tick;
        check("t2_hold_core_rst", 32'(core_rst), 32'd1);
        tick;
        check("t2_run_core_rst", 32'(core_rst), 32'd0);
        check("t2_run_done", 32'(done), 32'd1);
        check("t2_nwr", 32'(nwr), 32'd2);

        // T3: oversize count
        pulse_reload;
        send(8'h00); send(8'h41);
        check("t3_error", 32'(error), 32'd1);
        check("t3_core_rst", 32'(core_rst), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        in_valid = 1'b1;
        repeat (3) tick;
        check("t3_ready", 32'(in_ready), 32'd0);
        check("t3_sticky", 32'(error), 32'd1);
        in_valid = 1'b0;
        check("t3_nwr", 32'(nwr), 32'd2);
        pulse_reload;
        check("t3_reload_error", 32'(error), 32'd0);
        check("t3_reload_ready", 32'(in_ready), 32'd1);

        // T4: slow stream interrupted by reset, then a clean frame
        send_slow(8'h00); send_slow(8'h01); send_slow(8'h11);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("t4_rst_ready", 32'(in_ready), 32'd0);
        check("t4_rst_core_rst", 32'(core_rst), 32'd1);
        tick;
        check("t4_nwr_abort", 32'(nwr), 32'd2);
        send_slow(8'h00); send_slow(8'h01);
        send_slow(8'hAA); send_slow(8'hBB); send_slow(8'hCC); send_slow(8'hDD);
        check("t4_en", 32'(wr_en), 32'd1);
        check("t4_addr", 32'(wr_addr), 32'd0);
        check("t4_data", wr_data, 32'hAABB_CCDD);
        csum(8'h00);
        wait_run;
        check("t4_nwr", 32'(nwr), 32'd3);

        // T5: full depth
        pulse_reload;
        base = nwr;
        x = 8'h00;
        send(8'h00); send(8'h40);
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            exp_mem[i] = w;
            for (int b = 3; b >= 0; b--) begin
                x ^= w[8*b +: 8];
                send(w[8*b +: 8]);
            end
        end
        check("t5_last_en", 32'(wr_en), 32'd1);
        check("t5_last_addr", 32'(wr_addr), 32'd63);
        csum(x);
        wait_run;
        repeat (5) tick;
        check("t5_nwr", 32'(nwr - base), 32'd64);
        check("t5_last_written", 32'(last_addr), 32'd63);
        errs = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== exp_mem[i]) errs++;
        check("t5_readback_errs", 32'(errs), 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // T6: checksum good then bad
        pulse_reload;
        send(8'h00); send(8'h01);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        check("t6_data", wr_data, 32'h0102_0304);
        send(8'h04);
        wait_run;
        check("t6_good_error", 32'(error), 32'd0);
        pulse_reload;
        send(8'h00); send(8'h01);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h05);
        check("t6_bad_error", 32'(error), 32'd1);
        repeat (6) tick;
        check("t6_bad_core_rst", 32'(core_rst), 32'd1);
        check("t6_bad_done", 32'(done), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
